// File: rtl/vending_machine_top.sv
// Soda vending controller: accumulates nickel/dime/quarter credit (held in nickels),
// dispenses one soda when the price is reached and returns change in nickels.
module vending_machine_top #(
    parameter int unsigned PRICE_NICKELS = 4
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       nickel_i,
    input  logic       dime_i,
    input  logic       quarter_i,
    output logic       soda_o,
    output logic [2:0] change_o
);

    localparam int unsigned CREDIT_W = 5;
    localparam int unsigned CHANGE_W = 3;

    localparam logic [CREDIT_W-1:0] PRICE        = CREDIT_W'(PRICE_NICKELS);
    localparam logic [CREDIT_W-1:0] NICKEL_VALUE = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] DIME_VALUE   = CREDIT_W'(2);
    localparam logic [CREDIT_W-1:0] QUARTER_VALUE = CREDIT_W'(5);

    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [CREDIT_W-1:0] coin_value;
    logic [CREDIT_W-1:0] sum;
    logic                coin_valid;
    logic                soda_nxt;
    logic [CHANGE_W-1:0] change_nxt;

    // Credit and actuator registers; reset forfeits any accumulated credit.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            credit   <= '0;
            soda_o   <= 1'b0;
            change_o <= '0;
        end else begin
            credit   <= credit_nxt;
            soda_o   <= soda_nxt;
            change_o <= change_nxt;
        end
    end

    // Exactly one coin line high is a valid insertion; anything else is ignored.
    always_comb begin
        coin_valid = 1'b0;
        coin_value = '0;
        unique case ({quarter_i, dime_i, nickel_i})
            3'b001: begin
                coin_valid = 1'b1;
                coin_value = NICKEL_VALUE;
            end
            3'b010: begin
                coin_valid = 1'b1;
                coin_value = DIME_VALUE;
            end
            3'b100: begin
                coin_valid = 1'b1;
                coin_value = QUARTER_VALUE;
            end
            default: begin
                coin_valid = 1'b0;
                coin_value = '0;
            end
        endcase
    end

    // Vend decision: credit stays below price between vends, so change never exceeds 4.
    always_comb begin
        credit_nxt = credit;
        soda_nxt   = 1'b0;
        change_nxt = '0;
        sum        = credit + coin_value;
        if (coin_valid) begin
            if (sum >= PRICE) begin
                soda_nxt   = 1'b1;
                change_nxt = CHANGE_W'(sum - PRICE);
                credit_nxt = '0;
            end else begin
                credit_nxt = sum;
            end
        end
    end

endmodule

// File: tb/tb_vending_machine_top.sv
// Bench for vending_machine_top: directed steps then random coins, checked against
// a cents-based model of the vending rules.
module tb_vending_machine_top;

    localparam int PRICE_CENTS = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       nickel = 1'b0;
    logic       dime = 1'b0;
    logic       quarter = 1'b0;
    logic       soda;
    logic [2:0] change;

    int         compared = 0;
    int         mismatched = 0;
    int         model_cents = 0;
    logic       exp_soda = 1'b0;
    logic [2:0] exp_change = 3'd0;

    vending_machine_top #(.PRICE_NICKELS(4)) dut (
        .clk_i     (clk),
        .reset_ni  (reset_n),
        .nickel_i  (nickel),
        .dime_i    (dime),
        .quarter_i (quarter),
        .soda_o    (soda),
        .change_o  (change)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input string field,
                             input logic [7:0] obs, input logic [7:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s %s: observed %0d expected %0d", tag, field, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val(tag, "soda", {7'd0, soda}, {7'd0, exp_soda});
        check_val(tag, "change", {5'd0, change}, {5'd0, exp_change});
    endtask

    // Reference rules: credit in cents; a single coin adds its value, reaching the price vends.
    task automatic model_edge(input logic n, input logic d, input logic q);
        int cnt;
        int val;
        cnt = int'(n) + int'(d) + int'(q);
        exp_soda   = 1'b0;
        exp_change = 3'd0;
        if (!reset_n) begin
            model_cents = 0;
        end else if (cnt == 1) begin
            val = n ? 5 : (d ? 10 : 25);
            model_cents += val;
            if (model_cents >= PRICE_CENTS) begin
                exp_soda    = 1'b1;
                exp_change  = 3'((model_cents - PRICE_CENTS) / 5);
                model_cents = 0;
            end
        end
    endtask

    task automatic step(input string tag, input logic n, input logic d, input logic q);
        @(negedge clk);
        nickel  = n;
        dime    = d;
        quarter = q;
        @(posedge clk);
        #1;
        model_edge(n, d, q);
        check_outputs(tag);
    endtask

    // Called at posedge+1: assert reset mid-cycle and expect outputs to clear immediately.
    task automatic async_reset(input string tag);
        #2;
        nickel  = 1'b0;
        dime    = 1'b0;
        quarter = 1'b0;
        reset_n = 1'b0;
        #1;
        model_cents = 0;
        exp_soda    = 1'b0;
        exp_change  = 3'd0;
        check_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [2:0] bits;
        int unsigned r;

        #1;
        exp_soda   = 1'b0;
        exp_change = 3'd0;
        check_outputs("reset_t0");

        // Coins toggling while held in reset must have no effect.
        for (int i = 0; i < 4; i++) begin
            bits = 3'($urandom_range(0, 7));
            step("reset_hold", bits[0], bits[1], bits[2]);
        end
        @(negedge clk);
        nickel  = 1'b0;
        dime    = 1'b0;
        quarter = 1'b0;
        reset_n = 1'b1;
        step("post_reset", 1'b0, 1'b0, 1'b0);
        step("post_reset", 1'b0, 1'b0, 1'b0);

        step("two_dimes_1", 1'b0, 1'b1, 1'b0);
        step("two_dimes_idle", 1'b0, 1'b0, 1'b0);
        step("two_dimes_2", 1'b0, 1'b1, 1'b0);
        step("two_dimes_after", 1'b0, 1'b0, 1'b0);

        step("quarter", 1'b0, 1'b0, 1'b1);
        step("quarter_after", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) step("n3q_nickel", 1'b1, 1'b0, 1'b0);
        step("n3q_quarter", 1'b0, 1'b0, 1'b1);
        step("n3q_after", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) step("four_nickels", 1'b1, 1'b0, 1'b0);
        step("four_nickels_after", 1'b0, 1'b0, 1'b0);

        // Back-to-back vends on consecutive edges.
        step("b2b_q1", 1'b0, 1'b0, 1'b1);
        step("b2b_q2", 1'b0, 1'b0, 1'b1);
        step("b2b_after", 1'b0, 1'b0, 1'b0);

        step("invalid_pre_dime", 1'b0, 1'b1, 1'b0);
        step("invalid_dime_nickel", 1'b1, 1'b1, 1'b0);
        step("invalid_then_dime", 1'b0, 1'b1, 1'b0);
        step("invalid_after", 1'b0, 1'b0, 1'b0);

        // Reset while soda is being dispensed clears outputs asynchronously.
        step("vend_before_reset", 1'b0, 1'b0, 1'b1);
        async_reset("async_during_vend");

        for (int i = 0; i < 3; i++) step("fifteen_nickel", 1'b1, 1'b0, 1'b0);
        async_reset("async_at_15c");
        step("forfeit_n1", 1'b1, 1'b0, 1'b0);
        step("forfeit_n2", 1'b1, 1'b0, 1'b0);
        step("forfeit_n3", 1'b1, 1'b0, 1'b0);
        step("forfeit_n4", 1'b1, 1'b0, 1'b0);
        step("forfeit_after", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            if (r <= 5)       step("rand_idle", 1'b0, 1'b0, 1'b0);
            else if (r <= 9)  step("rand_nickel", 1'b1, 1'b0, 1'b0);
            else if (r <= 12) step("rand_dime", 1'b0, 1'b1, 1'b0);
            else if (r <= 15) step("rand_quarter", 1'b0, 1'b0, 1'b1);
            else if (r <= 18) begin
                bits = 3'($urandom_range(0, 7));
                step("rand_mixed", bits[0], bits[1], bits[2]);
            end else begin
                step("rand_pre_reset", 1'b0, 1'b0, 1'b0);
                async_reset("rand_async_reset");
            end
        end
        step("final_idle", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
